// File: rtl/s3_ex_result_buf.sv
// Two-entry skid buffer between s3 execute and s4 memory; normalises compare masks to 0/1.
// Optional macro S3_EX_MASK_CHECK_EN adds a sticky illegal-mask flag on mask_err.
module s3_ex_result_buf #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_mask,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb_en,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy,
  output logic              mask_err
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] head_result, skid_result;
  logic [RD_W-1:0]   head_rd, skid_rd;
  logic              head_wb, skid_wb;
  logic              push, pop;
  logic              load_head_in, load_skid_in, head_from_skid;
  logic [DATA_W-1:0] cap_result;
  logic              cap_wb;

  function automatic logic [DATA_W-1:0] norm_result(input logic [DATA_W-1:0] r,
                                                    input logic              is_mask);
    return is_mask ? {{(DATA_W-1){1'b0}}, r[0]} : r;
  endfunction

  assign in_ready   = (state != FULL);
  assign out_valid  = (state != EMPTY);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign cap_result = norm_result(in_result, in_is_mask);
  // x0 is hardwired; never let it look like a forwardable write.
  assign cap_wb     = in_wb_en & (in_rd != '0);

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_skid_in   = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (push && !pop) begin
            state_nxt    = FULL;
            load_skid_in = 1'b1;
          end else if (pop && !push) begin
            state_nxt = EMPTY;
          end else if (push && pop) begin
            load_head_in = 1'b1;
          end
        end
        FULL: if (pop) begin
          state_nxt      = ONE;
          head_from_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head_result <= '0;
      head_rd     <= '0;
      head_wb     <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_wb     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_head_in) begin
        head_result <= cap_result;
        head_rd     <= in_rd;
        head_wb     <= cap_wb;
      end else if (head_from_skid) begin
        head_result <= skid_result;
        head_rd     <= skid_rd;
        head_wb     <= skid_wb;
      end
      if (load_skid_in) begin
        skid_result <= cap_result;
        skid_rd     <= in_rd;
        skid_wb     <= cap_wb;
      end
    end
  end

  // Outputs come from head registers only, so s4 sees no in_* timing path.
  assign out_result = head_result;
  assign out_rd     = head_rd;
  assign out_wb_en  = head_wb;
  assign fwd_valid  = out_valid & head_wb;
  assign fwd_rd     = head_rd;
  assign fwd_data   = head_result;
  assign occupancy  = state;

`ifdef S3_EX_MASK_CHECK_EN
  logic mask_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_err_q <= 1'b0;
    end else if (push && !flush && in_is_mask && (in_result != '0) && (in_result != '1)) begin
      mask_err_q <= 1'b1;
    end
  end
  assign mask_err = mask_err_q;
`else
  assign mask_err = 1'b0;
`endif

endmodule

// File: tb/tb_s3_ex_result_buf.sv
// Randomised bench for s3_ex_result_buf against a queue-based FIFO model.
module tb_s3_ex_result_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, in_is_mask, in_wb_en;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_wb_en, fwd_valid, mask_err;
  logic [31:0] out_result, fwd_data;
  logic [4:0]  out_rd, fwd_rd;
  logic [1:0]  occupancy;

  s3_ex_result_buf #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_is_mask(in_is_mask), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wb_en(out_wb_en),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .occupancy(occupancy), .mask_err(mask_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
  } ent_t;

  ent_t q[$];
  logic merr = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("mask_err", 64'(mask_err), 64'(merr));
    if (q.size() > 0) begin
      chk("out_result", 64'(out_result), 64'(q[0].res));
      chk("out_rd", 64'(out_rd), 64'(q[0].rd));
      chk("out_wb_en", 64'(out_wb_en), 64'(q[0].wb));
      chk("fwd_valid", 64'(fwd_valid), 64'(q[0].wb));
      chk("fwd_rd", 64'(fwd_rd), 64'(q[0].rd));
      chk("fwd_data", 64'(fwd_data), 64'(q[0].res));
    end else begin
      chk("fwd_valid_empty", 64'(fwd_valid), 64'd0);
    end
  endtask

  // Drive one cycle from the negedge, advance the model, then check at the next negedge.
  task automatic step(input logic iv, input logic [31:0] res, input logic m,
                      input logic [4:0] rd, input logic wb, input logic ordy, input logic fl);
    bit   do_push, do_pop;
    ent_t e;
    in_valid = iv; in_result = res; in_is_mask = m; in_rd = rd; in_wb_en = wb;
    out_ready = ordy; flush = fl;
    do_push = iv && (q.size() < 2);
    do_pop  = (q.size() > 0) && ordy;
`ifdef S3_EX_MASK_CHECK_EN
    if (do_push && !fl && m && res != 32'h0 && res != 32'hFFFF_FFFF) merr = 1'b1;
`endif
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.res = m ? {31'd0, res[0]} : res;
        e.rd  = rd;
        e.wb  = wb && (rd != 5'd0);
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 0; in_result = 0; in_is_mask = 0; in_rd = 0; in_wb_en = 0;
    out_ready = 0; flush = 0;
    #1;
    q.delete();
    merr = 1'b0;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wb_en", 64'(out_wb_en), 64'd0);
    chk("rst_mask_err", 64'(mask_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic random_phase(input int n);
    logic [31:0] r;
    logic        m;
    logic [4:0]  rd;
    for (int i = 0; i < n; i++) begin
      m = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       r = 32'h0;
        1:       r = 32'hFFFF_FFFF;
        default: r = $urandom;
      endcase
      if (!m) r = $urandom;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      step(($urandom_range(0, 3) != 0), r, m, rd, 1'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    end
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check_outputs();

    // Mask all-ones becomes 1.
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("mask_norm", 64'(out_result), 64'h1);
    chk("mask_rd", 64'(out_rd), 64'd5);
    chk("mask_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("mask_occ", 64'(occupancy), 64'd1);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Fill while stalled, then drain in order.
    step(1'b1, 32'h11, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", 64'(out_result), 64'h11);
    idle(1'b1);
    chk("drain_second", 64'(out_result), 64'h22);
    idle(1'b1);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Back-to-back stream with s4 always ready.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hA0 + 32'(i), 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
      chk("stream_data", 64'(out_result), 64'hA0 + 64'(i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    idle(1'b1);

    // rd=0 suppresses write-back but keeps the data.
    step(1'b1, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("rd0_wb_en", 64'(out_wb_en), 64'd0);
    chk("rd0_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rd0_result", 64'(out_result), 64'h1234);
    idle(1'b1);

    // Flush while full with a concurrent push.
    step(1'b1, 32'h55, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h66, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);
    chk("flush_no_ghost", 64'(out_valid), 64'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Illegal mask value: captured via bit 0; flag only when the checker is built in.
    step(1'b1, 32'h3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("badmask_result", 64'(out_result), 64'h1);
`ifdef S3_EX_MASK_CHECK_EN
    chk("badmask_flag", 64'(mask_err), 64'd1);
`else
    chk("badmask_flag", 64'(mask_err), 64'd0);
`endif
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("badmask_after_flush", 64'(mask_err), 64'(merr));

    random_phase(600);
    do_reset();
    @(negedge clk);
    check_outputs();
    random_phase(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
